// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 host command sequencer.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StTxCmd   = 3'd1,
    StAckCmd  = 3'd2,
    StTxArg   = 3'd3,
    StAckArg  = 3'd4,
    StWaitBat = 3'd5,
    StFin     = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    StatOk      = 3'd0,
    StatNak     = 3'd1,
    StatTimeout = 3'd2,
    StatTxErr   = 3'd3,
    StatBatFail = 3'd4
  } status_e;

  // Device responses
  localparam logic [7:0] RespAck     = 8'hFA;
  localparam logic [7:0] RespResend  = 8'hFE;
  localparam logic [7:0] RespBatOk   = 8'hAA;
  localparam logic [7:0] RespBatFail = 8'hFC;

  // Host commands
  localparam logic [7:0] CmdSetLeds = 8'hED;
  localparam logic [7:0] CmdReset   = 8'hFF;
  localparam logic [7:0] CmdEnable  = 8'hF4;

endpackage

// File: rtl/ps2_timeout_cnt.sv
// Loadable down-counter; expire flags the cycle whose edge takes the count to zero.
module ps2_timeout_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] value,
  output logic             expire
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign expire = (cnt_q == Width'(1));

endmodule

// File: rtl/ps2_cmd_seq.sv
// PS/2 host command sequencer: sends command/argument bytes, handles ACK/resend/BAT,
// and forwards every unconsumed received byte as a scancode.
module ps2_cmd_seq #(
  parameter int unsigned TIMEOUT_CYC     = 2_000_000,
  parameter int unsigned BAT_TIMEOUT_CYC = 100_000_000,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [7:0] i_cmd_byte,
  input  logic       i_cmd_has_arg,
  input  logic [7:0] i_cmd_arg,
  input  logic       i_cmd_wait_bat,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_done,
  input  logic       i_tx_err,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_scan_valid,
  output logic [7:0] o_scan_data,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_status
);

  import ps2_pkg::*;

  localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  state_e            state_q, state_d;
  status_e           status_q, status_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        arg_q, arg_d;
  logic              has_arg_q, has_arg_d;
  logic              wait_bat_q, wait_bat_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              scan_valid_q, scan_valid_d;
  logic [7:0]        scan_data_q, scan_data_d;

  logic              consumed;
  logic              tmo_load;
  logic [31:0]       tmo_value;
  logic              tmo_expire;

  logic rx_ack, rx_resend, rx_bat_ok, rx_bat_fail;

  assign rx_ack      = i_rx_valid && (i_rx_data == RespAck);
  assign rx_resend   = i_rx_valid && (i_rx_data == RespResend);
  assign rx_bat_ok   = i_rx_valid && (i_rx_data == RespBatOk);
  assign rx_bat_fail = i_rx_valid && (i_rx_data == RespBatFail);

  ps2_timeout_cnt #(
    .Width (32)
  ) u_timeout (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .load   (tmo_load),
    .value  (tmo_value),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    retry_d    = retry_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    has_arg_d  = has_arg_q;
    wait_bat_d = wait_bat_q;
    consumed   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          cmd_d      = i_cmd_byte;
          arg_d      = i_cmd_arg;
          has_arg_d  = i_cmd_has_arg;
          wait_bat_d = i_cmd_wait_bat;
          retry_d    = '0;
          state_d    = StTxCmd;
        end
      end
      StTxCmd, StTxArg: begin
        if (i_tx_done) begin
          state_d = (state_q == StTxCmd) ? StAckCmd : StAckArg;
        end else if (i_tx_err) begin
          state_d  = StFin;
          status_d = StatTxErr;
        end
      end
      StAckCmd, StAckArg: begin
        // A consuming response wins over a coincident timeout expiry.
        if (rx_ack) begin
          consumed = 1'b1;
          if (state_q == StAckArg) begin
            state_d  = StFin;
            status_d = StatOk;
          end else if (has_arg_q) begin
            state_d = StTxArg;
            retry_d = '0;
          end else if (wait_bat_q) begin
            state_d = StWaitBat;
          end else begin
            state_d  = StFin;
            status_d = StatOk;
          end
        end else if (rx_resend) begin
          consumed = 1'b1;
          if (retry_q == RetryMax) begin
            state_d  = StFin;
            status_d = StatNak;
          end else begin
            state_d = (state_q == StAckCmd) ? StTxCmd : StTxArg;
            retry_d = retry_q + RetryW'(1);
          end
        end else if (tmo_expire) begin
          state_d  = StFin;
          status_d = StatTimeout;
        end
      end
      StWaitBat: begin
        if (rx_bat_ok) begin
          consumed = 1'b1;
          state_d  = StFin;
          status_d = StatOk;
        end else if (rx_bat_fail) begin
          consumed = 1'b1;
          state_d  = StFin;
          status_d = StatBatFail;
        end else if (tmo_expire) begin
          state_d  = StFin;
          status_d = StatTimeout;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    tx_data_d = tx_data_q;
    if (state_d == StTxCmd) begin
      tx_data_d = cmd_d;
    end else if (state_d == StTxArg) begin
      tx_data_d = arg_q;
    end

    // Reload on every state change so the count always belongs to the current wait.
    tmo_load  = (state_d != state_q);
    tmo_value = '0;
    if (state_d == StAckCmd || state_d == StAckArg) begin
      tmo_value = TIMEOUT_CYC;
    end else if (state_d == StWaitBat) begin
      tmo_value = BAT_TIMEOUT_CYC;
    end

    scan_valid_d = i_rx_valid && !consumed;
    scan_data_d  = scan_valid_d ? i_rx_data : scan_data_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      status_q     <= StatOk;
      retry_q      <= '0;
      cmd_q        <= '0;
      arg_q        <= '0;
      has_arg_q    <= 1'b0;
      wait_bat_q   <= 1'b0;
      tx_data_q    <= '0;
      scan_valid_q <= 1'b0;
      scan_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      retry_q      <= retry_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      has_arg_q    <= has_arg_d;
      wait_bat_q   <= wait_bat_d;
      tx_data_q    <= tx_data_d;
      scan_valid_q <= scan_valid_d;
      scan_data_q  <= scan_data_d;
    end
  end

  assign o_cmd_ready  = (state_q == StIdle);
  assign o_busy       = (state_q != StIdle);
  assign o_tx_valid   = (state_q == StTxCmd) || (state_q == StTxArg);
  assign o_tx_data    = tx_data_q;
  assign o_done       = (state_q == StFin);
  assign o_status     = status_q;
  assign o_scan_valid = scan_valid_q;
  assign o_scan_data  = scan_data_q;

endmodule

// File: tb/tb_ps2_cmd_seq.sv
// Directed bench for ps2_cmd_seq; the bench plays both tx engine and PS/2 device.
module tb_ps2_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_has_arg = 1'b0;
  logic [7:0] cmd_arg = 8'h00;
  logic       cmd_wait_bat = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic       tx_err = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       scan_valid;
  logic [7:0] scan_data;
  logic       busy;
  logic       done;
  logic [2:0] status;

  int checks = 0;
  int errors = 0;
  int scan_cnt = 0;
  logic [7:0] tx_log[$];

  ps2_cmd_seq #(
    .TIMEOUT_CYC     (50),
    .BAT_TIMEOUT_CYC (300),
    .MAX_RETRY       (3)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_byte     (cmd_byte),
    .i_cmd_has_arg  (cmd_has_arg),
    .i_cmd_arg      (cmd_arg),
    .i_cmd_wait_bat (cmd_wait_bat),
    .o_tx_valid     (tx_valid),
    .o_tx_data      (tx_data),
    .i_tx_done      (tx_done),
    .i_tx_err       (tx_err),
    .i_rx_valid     (rx_valid),
    .i_rx_data      (rx_data),
    .o_scan_valid   (scan_valid),
    .o_scan_data    (scan_data),
    .o_busy         (busy),
    .o_done         (done),
    .o_status       (status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (scan_valid) scan_cnt++;

  task automatic issue_cmd(input logic [7:0] b, input logic has_arg, input logic [7:0] arg,
                           input logic wait_bat);
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_byte     = b;
    cmd_has_arg  = has_arg;
    cmd_arg      = arg;
    cmd_wait_bat = wait_bat;
    @(negedge clk);
    cmd_valid    = 1'b0;
  endtask

  // Acts as the tx engine: waits for a request, logs the byte, pulses done.
  task automatic serve_tx();
    int n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      checks++;
      errors++;
      $display("FAIL serve_tx: o_tx_valid=0 after %0d cycles, required 1", n);
    end else begin
      tx_log.push_back(tx_data);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc, output logic [2:0] st);
    cyc = 0;
    while (!done && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: o_done=0 after %0d cycles, required 1", cyc);
      st = 3'h7;
    end else begin
      st = status;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL rst_scan_valid: got %b want 0", scan_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    checks++; if (scan_data !== 8'h00) begin errors++; $display("FAIL rst_scan_data: got %h want 00", scan_data); end
    checks++; if (status !== 3'd0) begin errors++; $display("FAIL rst_status: got %0d want 0", status); end
    rst_n = 1'b1;
  endtask

  task automatic test_set_leds();
    int cyc;
    logic [2:0] st;
    int base = scan_cnt;
    tx_log.delete();
    issue_cmd(8'hED, 1'b1, 8'h07, 1'b0);
    serve_tx();
    send_rx(8'hFA);
    serve_tx();
    send_rx(8'hFA);
    wait_done(20, cyc, st);
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL leds_status: got %0d want 0", st); end
    checks++; if (tx_log.size() != 2) begin errors++; $display("FAIL leds_tx_count: got %0d want 2", tx_log.size()); end
    checks++; if (tx_log[0] !== 8'hED) begin errors++; $display("FAIL leds_tx0: got %h want ED", tx_log[0]); end
    checks++; if (tx_log[1] !== 8'h07) begin errors++; $display("FAIL leds_tx1: got %h want 07", tx_log[1]); end
    checks++; if (scan_cnt != base) begin errors++; $display("FAIL leds_no_scan: got %0d scans want 0", scan_cnt - base); end
  endtask

  task automatic test_bat();
    logic [7:0] resp [2];
    logic [2:0] want [2];
    int cyc;
    logic [2:0] st;
    resp[0] = 8'hAA; want[0] = 3'd0;
    resp[1] = 8'hFC; want[1] = 3'd4;
    for (int i = 0; i < 2; i++) begin
      tx_log.delete();
      issue_cmd(8'hFF, 1'b0, 8'h00, 1'b1);
      serve_tx();
      send_rx(8'hFA);
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL bat_waiting[%0d]: busy=%b done=%b want 1 0", i, busy, done); end
      send_rx(resp[i]);
      wait_done(20, cyc, st);
      checks++; if (st !== want[i]) begin errors++; $display("FAIL bat_status[%0d]: got %0d want %0d", i, st, want[i]); end
      checks++; if (tx_log.size() != 1) begin errors++; $display("FAIL bat_tx_count[%0d]: got %0d want 1", i, tx_log.size()); end
      checks++; if (tx_log[0] !== 8'hFF) begin errors++; $display("FAIL bat_tx0[%0d]: got %h want FF", i, tx_log[0]); end
    end
  endtask

  task automatic test_resend();
    int cyc;
    logic [2:0] st;
    tx_log.delete();
    issue_cmd(8'hF4, 1'b0, 8'h00, 1'b0);
    serve_tx(); send_rx(8'hFE);
    serve_tx(); send_rx(8'hFE);
    serve_tx(); send_rx(8'hFA);
    wait_done(20, cyc, st);
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL resend_ok_status: got %0d want 0", st); end
    checks++; if (tx_log.size() != 3) begin errors++; $display("FAIL resend_ok_count: got %0d want 3", tx_log.size()); end
    for (int i = 0; i < tx_log.size(); i++) begin
      checks++; if (tx_log[i] !== 8'hF4) begin errors++; $display("FAIL resend_ok_byte[%0d]: got %h want F4", i, tx_log[i]); end
    end
    tx_log.delete();
    issue_cmd(8'hF4, 1'b0, 8'h00, 1'b0);
    repeat (4) begin
      serve_tx();
      send_rx(8'hFE);
    end
    wait_done(20, cyc, st);
    checks++; if (st !== 3'd1) begin errors++; $display("FAIL resend_nak_status: got %0d want 1", st); end
    checks++; if (tx_log.size() != 4) begin errors++; $display("FAIL resend_nak_count: got %0d want 4", tx_log.size()); end
  endtask

  task automatic test_scan();
    int cyc;
    logic [2:0] st;
    tx_log.delete();
    issue_cmd(8'hF4, 1'b0, 8'h00, 1'b0);
    serve_tx();
    send_rx(8'h1C);
    checks++; if (scan_valid !== 1'b1) begin errors++; $display("FAIL scan_valid: got %b want 1", scan_valid); end
    checks++; if (scan_data !== 8'h1C) begin errors++; $display("FAIL scan_data: got %h want 1C", scan_data); end
    checks++; if (busy !== 1'b1 || tx_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL scan_in_ack: busy=%b tx_valid=%b done=%b want 1 0 0", busy, tx_valid, done); end
    send_rx(8'hFA);
    wait_done(20, cyc, st);
    checks++; if (cyc != 0 || st !== 3'd0) begin errors++; $display("FAIL scan_then_ack: cyc=%0d status=%0d want 0 0", cyc, st); end
    checks++; if (tx_log.size() != 1) begin errors++; $display("FAIL scan_tx_count: got %0d want 1", tx_log.size()); end
  endtask

  task automatic test_timeout();
    int k = 0;
    int cyc;
    logic [2:0] st;
    issue_cmd(8'hF4, 1'b0, 8'h00, 1'b0);
    serve_tx();
    // Now one cycle into ACK_CMD; done must appear 50 edges after entry.
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k != 50) begin errors++; $display("FAIL timeout_latency: got %0d cycles want 50", k); end
    checks++; if (status !== 3'd2) begin errors++; $display("FAIL timeout_status: got %0d want 2", status); end
    issue_cmd(8'hF4, 1'b0, 8'h00, 1'b0);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL txerr_tx_valid: got %b want 1", tx_valid); end
    tx_err = 1'b1;
    @(negedge clk);
    tx_err = 1'b0;
    wait_done(20, cyc, st);
    checks++; if (st !== 3'd3) begin errors++; $display("FAIL txerr_status: got %0d want 3", st); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL txerr_tx_dropped: got %b want 0", tx_valid); end
  endtask

  task automatic test_reset_mid();
    issue_cmd(8'hED, 1'b1, 8'h12, 1'b0);
    serve_tx();
    send_rx(8'hFA);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h12) begin errors++; $display("FAIL mid_in_tx_arg: tx_valid=%b data=%h want 1 12", tx_valid, tx_data); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid: got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_busy_done: busy=%b done=%b want 0 0", busy, done); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
    checks++; if (scan_valid !== 1'b0 || scan_data !== 8'h00) begin errors++; $display("FAIL mid_scan: valid=%b data=%h want 0 00", scan_valid, scan_data); end
    checks++; if (status !== 3'd0) begin errors++; $display("FAIL mid_status: got %0d want 0", status); end
  endtask

  initial begin
    test_reset();
    test_set_leds();
    test_bat();
    test_resend();
    test_scan();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_seq.md
PS2_CMD_SEQ -- requirements
Module: ps2_cmd_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 2_000_000, wait-state timeout in i_clk cycles (20 ms at 100 MHz).
REQ-002 SHALL have parameter BAT_TIMEOUT_CYC, default 100_000_000, BAT wait timeout in cycles.
REQ-003 SHALL have parameter MAX_RETRY, default 3, resend attempts allowed per transmitted byte after a 0xFE response.
REQ-004 SHALL have ports in this order:
- i_clk  in  1  clock; one clock domain.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  high only in IDLE.
- i_cmd_byte  in  8  command byte, e.g. 0xED or 0xFF.
- i_cmd_has_arg  in  1  an argument byte follows the command.
- i_cmd_arg  in  8  argument byte.
- i_cmd_wait_bat  in  1  wait for BAT result after ACK.
- o_tx_valid  out  1  request to the PS/2 host-to-device tx engine; held until i_tx_done or i_tx_err.
- o_tx_data  out  8  byte to transmit.
- i_tx_done  in  1  one-cycle tx complete.
- i_tx_err  in  1  one-cycle tx failure; device did not clock or sent no line ACK.
- i_rx_valid  in  1  one-cycle received-byte strobe from key_con.
- i_rx_data  in  8  received byte.
- o_scan_valid  out  1  one-cycle forwarded scancode strobe.
- o_scan_data  out  8  forwarded scancode.
- o_busy  out  1  state is not IDLE.
- o_done  out  1  one-cycle command completion pulse.
- o_status  out  3  result, valid with o_done: 0 OK, 1 NAK, 2 TIMEOUT, 3 TX_ERR, 4 BAT_FAIL.

Function
REQ-005 SHALL implement states IDLE, TX_CMD, ACK_CMD, TX_ARG, ACK_ARG, WAIT_BAT, FIN.
REQ-006 SHALL capture byte, arg, has_arg and wait_bat when i_cmd_valid and o_cmd_ready are high in the same cycle, then enter TX_CMD on the next cycle.
REQ-007 SHALL assert o_tx_valid in TX_CMD or TX_ARG, starting the cycle after entry.
REQ-008 On i_tx_done, SHALL go to the matching ACK state. On i_tx_err, SHALL go to FIN with status TX_ERR.
REQ-009 On entry to ACK_CMD, ACK_ARG or WAIT_BAT, SHALL load the timeout counter:
- TIMEOUT_CYC for ACK states.
- BAT_TIMEOUT_CYC for WAIT_BAT.
REQ-010 SHALL decrement the timeout counter each cycle, and SHALL go to FIN with status TIMEOUT when the counter reaches 0.
REQ-011 In an ACK state, rx 0xFA SHALL advance the sequence:
- ACK_CMD goes to TX_ARG if has_arg.
- Otherwise it goes to WAIT_BAT if wait_bat.
- Otherwise it goes to FIN with status OK.
- ACK_ARG goes to FIN with status OK.
REQ-012 In an ACK state, rx 0xFE SHALL re-enter the same TX state and increment the retry counter.
REQ-013 If the retry counter already equals MAX_RETRY, rx 0xFE SHALL go to FIN with status NAK instead.
REQ-014 SHALL reset the retry counter on each new TX_CMD or TX_ARG entry that is not a resend.
REQ-015 In WAIT_BAT, rx 0xAA SHALL go to FIN with status OK, and rx 0xFC SHALL go to FIN with status BAT_FAIL.
REQ-016 SHALL forward every rx byte not consumed by REQ-011, REQ-012, REQ-013 or REQ-015 to o_scan_valid/o_scan_data in the next cycle, in any state.
REQ-017 If a consuming rx byte and timeout expiry occur in the same cycle, the rx byte SHALL take priority.
REQ-018 FIN SHALL last one cycle, drive o_done=1 with o_status, and then return to IDLE.
REQ-019 o_status SHALL hold its value until the next FIN.
REQ-020 A command request held high while not in IDLE SHALL be ignored until IDLE is reached.
REQ-021 i_tx_done or i_tx_err arriving outside the TX states SHALL be ignored.

Reset
REQ-022 When i_rst_n is low at a rising edge of i_clk, SHALL return to IDLE within one cycle, including mid-command.
REQ-023 Reset values SHALL be:
- o_cmd_ready=1 (it is high in IDLE).
- o_tx_valid, o_scan_valid, o_busy, o_done = 0.
- o_tx_data, o_scan_data = 0x00.
- o_status = 0.
- Timeout and retry counters cleared.

Structure
REQ-024 A shared package ps2_pkg SHALL hold:
- The state enum.
- The status enum.
- Device response constants 0xFA, 0xFE, 0xAA, 0xFC.
- Host command constants 0xED (set LEDs), 0xFF (reset), 0xF4 (enable).
REQ-025 A single sub-module ps2_timeout_cnt (load, value, expire) SHALL implement the timeout counter; this block SHALL contain no other sub-modules.

Verification
REQ-026 Bench SHALL cover: cmd 0xED with arg 0x07; device answers FA, FA -> tx bytes 0xED then 0x07; o_done with status 0; no scan output.
REQ-027 Bench SHALL cover: cmd 0xFF with wait_bat; answers FA, AA -> one tx byte; status 0. Same sequence with FC instead of AA -> status 4.
REQ-028 Bench SHALL cover: cmd 0xF4; device answers FE, FE, FA -> 0xF4 transmitted 3 times; status 0. Four consecutive FE -> 4 transmissions; status 1.
REQ-029 Bench SHALL cover: no response with TIMEOUT_CYC=50 -> o_done exactly 50 cycles after ACK_CMD entry; status 2. Then i_tx_err during TX_CMD -> status 3.
REQ-030 Bench SHALL cover: rx 0x1C while in ACK_CMD -> o_scan_data=0x1C forwarded while the state machine stays in ACK_CMD. Then reset asserted mid-TX_ARG -> all outputs at reset values, o_cmd_ready=1 next cycle.
